// File: rtl/label_neighbor_buffer_if.sv
// Pixel-stream / labeler bundle between the upstream source, the labeler and the
// neighbour-context buffer.
interface label_neighbor_buffer_if #(
  parameter int unsigned LABEL_WIDTH = 8,
  parameter int unsigned X_WIDTH     = 9,
  parameter int unsigned Y_WIDTH     = 8
);
  logic                   pixel_valid;
  logic                   motion_in;
  logic                   frame_end_in;
  logic [LABEL_WIDTH-1:0] current_label;
  logic                   enable;
  logic                   motion_pixel;
  logic                   last_in_frame;
  logic [LABEL_WIDTH-1:0] left_label;
  logic [LABEL_WIDTH-1:0] top_label;
  logic [X_WIDTH-1:0]     pixel_x;
  logic [Y_WIDTH-1:0]     pixel_y;

  // Stream source plus labeler result side
  modport master (
    output pixel_valid, motion_in, frame_end_in, current_label,
    input  enable, motion_pixel, last_in_frame, left_label, top_label, pixel_x, pixel_y
  );

  // Neighbour-context buffer side
  modport slave (
    input  pixel_valid, motion_in, frame_end_in, current_label,
    output enable, motion_pixel, last_in_frame, left_label, top_label, pixel_x, pixel_y
  );
endinterface

// File: rtl/label_neighbor_buffer.sv
// Aligns each raster pixel with its left/top neighbour labels for the connected-component
// labeler and captures the labeler result into a one-row label line buffer.
module label_neighbor_buffer #(
  parameter int unsigned LABEL_WIDTH = 8,
  parameter int unsigned IMG_WIDTH   = 320,
  parameter int unsigned IMG_HEIGHT  = 240,
  parameter int unsigned X_WIDTH     = $clog2(IMG_WIDTH),
  parameter int unsigned Y_WIDTH     = $clog2(IMG_HEIGHT)
) (
  input logic clk,
  input logic rst,
  label_neighbor_buffer_if.slave bus
);

  localparam int unsigned LAST_COL = IMG_WIDTH - 1;
  localparam int unsigned LAST_ROW = IMG_HEIGHT - 1;

  logic [X_WIDTH-1:0]     r_col;
  logic [Y_WIDTH-1:0]     r_row;
  logic                   r_first_row;
  logic                   r_s2_valid;
  logic                   r_s2_motion;
  logic                   r_s2_last;
  logic [X_WIDTH-1:0]     r_s2_x;
  logic [Y_WIDTH-1:0]     r_s2_y;
  logic [LABEL_WIDTH-1:0] r_top;
  logic [LABEL_WIDTH-1:0] r_left;
  logic [LABEL_WIDTH-1:0] r_mem [IMG_WIDTH];

  logic [X_WIDTH-1:0]     w_col_nxt;
  logic [Y_WIDTH-1:0]     w_row_nxt;
  logic                   w_first_row_nxt;

  // Raster position after the accepted pixel; frame end wins over wrap/saturation
  always_comb begin
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_first_row_nxt = r_first_row;
    if (bus.frame_end_in) begin
      w_col_nxt       = '0;
      w_row_nxt       = '0;
      w_first_row_nxt = 1'b1;
    end else if (r_col == X_WIDTH'(LAST_COL)) begin
      w_col_nxt       = '0;
      w_first_row_nxt = 1'b0;
      if (r_row != Y_WIDTH'(LAST_ROW)) begin
        w_row_nxt = r_row + Y_WIDTH'(1);
      end
    end else begin
      w_col_nxt = r_col + X_WIDTH'(1);
    end
  end

  // Stage 1 accept / stage 2 labeler cycle; reset drops stage-2 valid immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_first_row <= 1'b1;
      r_s2_valid  <= 1'b0;
      r_s2_motion <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_x      <= '0;
      r_s2_y      <= '0;
      r_top       <= '0;
      r_left      <= '0;
    end else begin
      r_s2_valid  <= bus.pixel_valid;
      r_s2_motion <= bus.pixel_valid & bus.motion_in;
      r_s2_last   <= bus.pixel_valid & bus.frame_end_in;
      if (bus.pixel_valid) begin
        r_col       <= w_col_nxt;
        r_row       <= w_row_nxt;
        r_first_row <= w_first_row_nxt;
        r_s2_x      <= r_col;
        r_s2_y      <= r_row;
        // Stale buffer contents are never cleared, only masked in the first row
        r_top       <= r_first_row ? '0 : r_mem[r_col];
      end
      if (r_s2_valid) begin
        r_left <= bus.current_label;
      end
    end
  end

  // Line buffer write; read address (col) always runs one column ahead of this one
  always_ff @(posedge clk) begin
    if (r_s2_valid) begin
      r_mem[r_s2_x] <= bus.current_label;
    end
  end

  assign bus.enable        = r_s2_valid;
  assign bus.motion_pixel  = r_s2_motion;
  assign bus.last_in_frame = r_s2_last;
  assign bus.pixel_x       = r_s2_x;
  assign bus.pixel_y       = r_s2_y;
  assign bus.top_label     = r_top;
  assign bus.left_label    = (r_s2_x == '0) ? '0 : r_left;

endmodule

// File: tb/tb_label_neighbor_buffer.sv
// Self-checking bench for label_neighbor_buffer: table of pixel vectors with a reference
// neighbour model, scoreboard queue compared on labeler cycles, plus a mid-stream reset.
module tb_label_neighbor_buffer;
  localparam int unsigned LW = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned XW = 3;
  localparam int unsigned YW = 2;
  localparam int NV = 60;

  typedef struct {
    logic motion;
    logic fe;
    int   gap;
    int   ex;
    int   ey;
    int   eleft;
    int   etop;
    logic elast;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  label_neighbor_buffer_if #(.LABEL_WIDTH(LW), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  label_neighbor_buffer #(
    .LABEL_WIDTH(LW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_WIDTH(XW), .Y_WIDTH(YW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  vec_t          vecs [NV];
  vec_t          sb [$];
  vec_t          mv;
  vec_t          hv;
  logic [LW-1:0] lab [H][W];
  int            n_checks = 0;
  int            n_fail = 0;
  logic          pv_q = 1'b0;
  logic          mon_off = 1'b1;

  // reference neighbour model state
  int            mx, my;
  logic          mfirst;
  logic [LW-1:0] mline [W];
  logic [LW-1:0] mprev;

  // model labeler: returns a fixed label per (x, y) while enabled
  assign bus.current_label = bus.enable ? lab[bus.pixel_y][bus.pixel_x] : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mfirst = 1'b1; mprev = '0;
  endtask

  task automatic gen(input logic fe, input int gap, output vec_t v);
    v.ex     = mx;
    v.ey     = my;
    v.etop   = mfirst ? 0 : int'(mline[mx]);
    v.eleft  = (mx == 0) ? 0 : int'(mprev);
    v.motion = (lab[my][mx] != '0);
    v.fe     = fe;
    v.elast  = fe;
    v.gap    = gap;
    mline[mx] = lab[my][mx];
    mprev     = lab[my][mx];
    if (fe) begin
      mx = 0; my = 0; mfirst = 1'b1;
    end else if (mx == W - 1) begin
      mx = 0; mfirst = 1'b0;
      if (my != H - 1) my++;
    end else begin
      mx++;
    end
  endtask

  task automatic apply(input vec_t v);
    for (int g = 0; g < v.gap; g++) begin
      bus.pixel_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.pixel_valid  = 1'b1;
    bus.motion_in    = v.motion;
    bus.frame_end_in = v.fe;
    sb.push_back(v);
    @(posedge clk); #1;
    bus.pixel_valid  = 1'b0;
    bus.motion_in    = 1'b0;
    bus.frame_end_in = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 10 && sb.size() != 0; c++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(posedge clk or posedge rst) pv_q <= rst ? 1'b0 : bus.pixel_valid;

  // scoreboard monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (!mon_off) begin
      chk("enable", 32'(bus.enable), 32'(pv_q));
      if (bus.enable === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: got unexpected pixel expected none");
        end else begin
          mv = sb.pop_front();
          chk("pixel_x", 32'(bus.pixel_x), 32'(mv.ex));
          chk("pixel_y", 32'(bus.pixel_y), 32'(mv.ey));
          chk("motion_pixel", 32'(bus.motion_pixel), 32'(mv.motion));
          chk("last_in_frame", 32'(bus.last_in_frame), 32'(mv.elast));
          chk("left_label", 32'(bus.left_label), 32'(mv.eleft));
          chk("top_label", 32'(bus.top_label), 32'(mv.etop));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_enable"}, 32'(bus.enable), 32'd0);
    chk({tag, "_motion"}, 32'(bus.motion_pixel), 32'd0);
    chk({tag, "_last"}, 32'(bus.last_in_frame), 32'd0);
    chk({tag, "_left"}, 32'(bus.left_label), 32'd0);
    chk({tag, "_top"}, 32'(bus.top_label), 32'd0);
    chk({tag, "_x"}, 32'(bus.pixel_x), 32'd0);
    chk({tag, "_y"}, 32'(bus.pixel_y), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bus.pixel_valid  = 1'b0;
    bus.motion_in    = 1'b0;
    bus.frame_end_in = 1'b0;

    // labels y*10+x+1; two background holes (row 1 col 2 overwrites row 0 label 3)
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        lab[y][x] = LW'(y * 10 + x + 1);
    lab[1][2] = '0;
    lab[2][6] = '0;

    // vector table: gap-free rows 0-2 ending early at (3,2), then a stalled frame into row saturation
    model_reset();
    idx = 0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < int'(W); x++)
        if (!(y == 2 && x > 3)) begin
          gen(y == 2 && x == 3, 0, vecs[idx]);
          idx++;
        end
    for (int k = 0; k < 40; k++) begin
      gen(k == 39, (k < 24) ? int'($urandom_range(0, 5)) : 0, vecs[idx]);
      idx++;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mon_off = 1'b0;

    for (int i = 0; i < NV; i++) apply(vecs[i]);
    drain();
    repeat (3) @(posedge clk);
    #1;

    // mid-stream reset right after a pixel is accepted
    model_reset();
    gen(1'b0, 0, hv); apply(hv);
    gen(1'b0, 0, hv); apply(hv);
    bus.pixel_valid = 1'b1;
    bus.motion_in   = 1'b1;
    @(posedge clk); #1;
    mon_off = 1'b1;
    rst = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.motion_in   = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_off = 1'b0;
    model_reset();
    gen(1'b0, 0, hv); apply(hv);
    gen(1'b0, 1, hv); apply(hv);
    drain();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
